// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types, defaults and width helper for the clock frequency meter
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } meter_state_e;

  localparam int unsigned DEF_GATE_CYCLES = 64;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Wide enough to hold the value GATE_CYCLES itself.
  function automatic int unsigned gate_cnt_w(input int unsigned gate_cycles);
    return $clog2(gate_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// rtl/sync_rise_det.sv - multi-stage synchronizer with single-cycle rising-edge detect
module sync_rise_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// rtl/clk_freq_meter.sv - counts rising edges of a divided clock over a fixed gate window
module clk_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow
);

  localparam int unsigned         GATE_W    = gate_cnt_w(GATE_CYCLES);
  localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

  meter_state_e      state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              rise;

  sync_rise_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (div_clk_in),
    .rise_o (rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gate_q     <= '0;
      edge_q     <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      edge_q     <= edge_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    edge_d     = edge_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARM;
      end
      ST_ARM: begin
        gate_d  = '0;
        edge_d  = '0;
        ovf_d   = 1'b0;
        state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        gate_d = gate_q + GATE_W'(1);
        if (rise) begin
          if (edge_q == CNT_MAX) ovf_d = 1'b1;
          else                   edge_d = edge_q + CNT_W'(1);
        end
        // Result registers load on entry to DONE so they are already valid during the strobe.
        if (gate_q == GATE_LAST) begin
          state_d    = ST_DONE;
          count_d    = edge_d;
          overflow_d = ovf_d;
        end
      end
      ST_DONE: begin
        state_d = continuous ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign count_valid = (state_q == ST_DONE);
  assign count       = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb/tb_clk_freq_meter.sv - self-checking bench for clk_freq_meter (16-bit and 3-bit counters)
module tb_clk_freq_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_clk_in = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        busy16, cv16, ovf16;
  logic [15:0] cnt16;
  logic        busy3, cv3, ovf3;
  logic [2:0]  cnt3;

  int total = 0;
  int bad = 0;
  int n_strobe = 0;
  int exp_strobe = 0;
  int mode = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] c16;
    logic        o16;
    logic [2:0]  c3;
    logic        o3;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  clk_freq_meter #(.GATE_CYCLES(64), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .div_clk_in(div_clk_in), .start(start), .continuous(continuous),
    .busy(busy16), .count(cnt16), .count_valid(cv16), .overflow(ovf16)
  );

  clk_freq_meter #(.GATE_CYCLES(64), .CNT_W(3), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rst(rst), .div_clk_in(div_clk_in), .start(start), .continuous(continuous),
    .busy(busy3), .count(cnt3), .count_valid(cv3), .overflow(ovf3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] c16, input logic o16, input logic [2:0] c3, input logic o3);
    exp_t e;
    e.c16 = c16; e.o16 = o16; e.c3 = c3; e.o3 = o3;
    sb.push_back(e);
    exp_strobe++;
  endtask

  task automatic wait_strobe(input string tag);
    int k;
    logic found;
    k = 0;
    found = 1'b0;
    while (!found && k < 300) begin
      @(negedge clk);
      k++;
      if (cv16) found = 1'b1;
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_single(input int m, input logic [15:0] c16, input logic o16,
                            input logic [2:0] c3, input logic o3, input string tag);
    int s;
    mode = m;
    repeat (10) @(negedge clk);
    push(c16, o16, c3, o3);
    pulse_start(s);
    chk({tag, "_busy_rise"}, 32'(busy16), 32'd1);
    wait_strobe(tag);
    chk({tag, "_latency"}, 32'(cyc - s), 32'd66);
    @(negedge clk);
    chk({tag, "_busy_fall"}, 32'(busy16), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stimulus source: 0 const low, 1 const high, 2 divide-by-2, 3 divide-by-4.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph++;
      case (mode)
        0: div_clk_in = 1'b0;
        1: div_clk_in = 1'b1;
        2: div_clk_in = ~div_clk_in;
        default: if (ph % 2 == 0) div_clk_in = ~div_clk_in;
      endcase
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && cv16) begin
      n_strobe++;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("count16", 32'(cnt16), 32'(e.c16));
        chk("ovf16", 32'(ovf16), 32'(e.o16));
        chk("valid3", 32'(cv3), 32'd1);
        chk("count3", 32'(cnt3), 32'(e.c3));
        chk("ovf3", 32'(ovf3), 32'(e.o3));
      end
    end
  end

  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_count", 32'(cnt16), 32'd0);
    chk("rst_valid", 32'(cv16), 32'd0);
    chk("rst_ovf", 32'(ovf16), 32'd0);
    rst = 1'b0;

    // Divide-by-4 with a start pulse during the busy window that must be ignored.
    mode = 3;
    repeat (10) @(negedge clk);
    push(16'd16, 1'b0, 3'd7, 1'b1);
    pulse_start(s);
    chk("div4_busy_rise", 32'(busy16), 32'd1);
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_strobe("div4");
    chk("div4_latency", 32'(cyc - s), 32'd66);
    @(negedge clk);
    chk("div4_busy_fall", 32'(busy16), 32'd0);
    repeat (150) @(negedge clk);
    chk("ignored_start_strobes", 32'(n_strobe), 32'(exp_strobe));
    chk("ignored_start_busy", 32'(busy16), 32'd0);

    run_single(2, 16'd32, 1'b0, 3'd7, 1'b1, "div2");
    run_single(0, 16'd0, 1'b0, 3'd0, 1'b0, "const0");
    run_single(1, 16'd0, 1'b0, 3'd0, 1'b0, "const1");

    // Continuous mode: three back-to-back windows, then drop continuous mid-window.
    mode = 3;
    repeat (10) @(negedge clk);
    continuous = 1'b1;
    push(16'd16, 1'b0, 3'd7, 1'b1);
    pulse_start(s);
    wait_strobe("cont0");
    chk("cont0_latency", 32'(cyc - s), 32'd66);
    for (int i = 1; i <= 3; i++) begin
      s = cyc;
      push(16'd16, 1'b0, 3'd7, 1'b1);
      if (i == 3) begin
        repeat (10) @(negedge clk);
        continuous = 1'b0;
      end
      wait_strobe("cont");
      chk("cont_period", 32'(cyc - s), 32'd66);
    end
    @(negedge clk);
    chk("cont_stop_busy", 32'(busy16), 32'd0);
    repeat (150) @(negedge clk);
    chk("cont_stop_strobes", 32'(n_strobe), 32'(exp_strobe));

    // Reset 20 cycles into MEASURE.
    pulse_start(s);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy16), 32'd0);
    chk("midrst_count", 32'(cnt16), 32'd0);
    chk("midrst_valid", 32'(cv16), 32'd0);
    chk("midrst_ovf", 32'(ovf16), 32'd0);
    chk("midrst_busy3", 32'(busy3), 32'd0);
    chk("midrst_count3", 32'(cnt3), 32'd0);
    chk("midrst_ovf3", 32'(ovf3), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("midrst_no_strobe", 32'(n_strobe), 32'(exp_strobe));

    run_single(3, 16'd16, 1'b0, 3'd7, 1'b1, "after_rst");
    repeat (5) @(negedge clk);
    chk("final_strobes", 32'(n_strobe), 32'(exp_strobe));
    chk("final_queue", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
